// File: rtl/da_lut_sequencer.sv
// Frame sequencer for the parallel DA LUT datapath:
// weight frame handshake, LUT build sweep, bit-plane query beats.
module da_lut_sequencer #(
  parameter int K  = 8,
  parameter int XW = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  cont,
  input  logic                  abort,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  output logic                  w_load,
  output logic                  build_we,
  output logic [K-2:0]          build_addr,
  output logic                  q_valid,
  input  logic                  q_ready,
  output logic [$clog2(XW)-1:0] q_plane,
  output logic                  q_first,
  output logic                  q_last,
  output logic                  q_neg,
  output logic                  busy,
  output logic                  done
);

  localparam int PW = $clog2(XW);
  localparam logic [PW-1:0] LAST_PLANE = PW'(XW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_W,
    S_BUILD,
    S_QUERY,
    S_DONE
  } state_t;

  state_t        r_state;
  logic          r_frame_ready;
  logic          r_build_we;
  logic [K-2:0]  r_build_addr;
  logic          r_q_valid;
  logic [PW-1:0] r_q_plane;
  logic          r_busy;
  logic          r_done;

  logic w_build_last;
  logic w_plane_last;

  assign w_build_last = (r_build_addr == '1);
  assign w_plane_last = (r_q_plane == LAST_PLANE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_frame_ready <= 1'b0;
      r_build_we    <= 1'b0;
      r_build_addr  <= '0;
      r_q_valid     <= 1'b0;
      r_q_plane     <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else if (abort) begin
      r_state       <= S_IDLE;
      r_frame_ready <= 1'b0;
      r_build_we    <= 1'b0;
      r_build_addr  <= '0;
      r_q_valid     <= 1'b0;
      r_q_plane     <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state       <= S_WAIT_W;
            r_frame_ready <= 1'b1;
            r_busy        <= 1'b1;
          end
        end
        S_WAIT_W: begin
          if (frame_valid) begin
            r_state       <= S_BUILD;
            r_frame_ready <= 1'b0;
            r_build_we    <= 1'b1;
            r_build_addr  <= '0;
          end
        end
        S_BUILD: begin
          if (w_build_last) begin
            r_state      <= S_QUERY;
            r_build_we   <= 1'b0;
            r_build_addr <= '0;
            r_q_valid    <= 1'b1;
            r_q_plane    <= '0;
          end else begin
            r_build_addr <= r_build_addr + 1'b1;
          end
        end
        S_QUERY: begin
          // valid stays up until the last plane is accepted
          if (q_ready) begin
            if (w_plane_last) begin
              r_state   <= S_DONE;
              r_q_valid <= 1'b0;
              r_q_plane <= '0;
              r_done    <= 1'b1;
            end else begin
              r_q_plane <= r_q_plane + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_done <= 1'b0;
          if (cont) begin
            r_state       <= S_WAIT_W;
            r_frame_ready <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign frame_ready = r_frame_ready;
  assign build_we    = r_build_we;
  assign build_addr  = r_build_addr;
  assign q_valid     = r_q_valid;
  assign q_plane     = r_q_plane;
  assign busy        = r_busy;
  assign done        = r_done;

  assign w_load  = frame_valid & r_frame_ready;
  assign q_first = r_q_valid & (r_q_plane == '0);
  assign q_last  = r_q_valid & w_plane_last;
  assign q_neg   = q_last;

endmodule

// File: tb/tb_da_lut_sequencer.sv
// Randomized bench for da_lut_sequencer against a
// transaction-level model of frame timing and beat order.
module tb_da_lut_sequencer;

  localparam int K  = 8;
  localparam int XW = 8;
  localparam int PW = $clog2(XW);
  localparam int NB = 1 << (K - 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          cont = 1'b0;
  logic          abort = 1'b0;
  logic          frame_valid = 1'b0;
  logic          frame_ready;
  logic          w_load;
  logic          build_we;
  logic [K-2:0]  build_addr;
  logic          q_valid;
  logic          q_ready = 1'b0;
  logic [PW-1:0] q_plane;
  logic          q_first;
  logic          q_last;
  logic          q_neg;
  logic          busy;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt  = 0;
  int wload_cnt = 0;
  int bq[$];
  int pq[$];
  bit prev_stall = 1'b0;
  int prev_plane = 0;

  da_lut_sequencer #(.K(K), .XW(XW)) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont),
    .abort(abort), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .w_load(w_load),
    .build_we(build_we), .build_addr(build_addr),
    .q_valid(q_valid), .q_ready(q_ready),
    .q_plane(q_plane), .q_first(q_first),
    .q_last(q_last), .q_neg(q_neg),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // monitor: collect build writes and accepted beats
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", q_valid, 1);
        chk("hold_plane", q_plane, prev_plane);
      end
      if (build_we) bq.push_back(int'(build_addr));
      if (w_load) wload_cnt++;
      if (done) done_cnt++;
      if (q_valid && q_ready) begin
        automatic int k = pq.size() % XW;
        chk("q_first", q_first, k == 0);
        chk("q_last", q_last, k == XW - 1);
        chk("q_neg", q_neg, k == XW - 1);
        pq.push_back(int'(q_plane));
      end
      prev_stall = q_valid && !q_ready && !abort;
      prev_plane = int'(q_plane);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string t);
    chk({t, "_ready"}, frame_ready, 0);
    chk({t, "_wload"}, w_load, 0);
    chk({t, "_we"}, build_we, 0);
    chk({t, "_addr"}, build_addr, 0);
    chk({t, "_qvalid"}, q_valid, 0);
    chk({t, "_plane"}, q_plane, 0);
    chk({t, "_first"}, q_first, 0);
    chk({t, "_last"}, q_last, 0);
    chk({t, "_neg"}, q_neg, 0);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_done"}, done, 0);
  endtask

  task automatic check_seqs(input int frames);
    int e = 0;
    chk("build_n", bq.size(), frames * NB);
    foreach (bq[i]) if (bq[i] != i % NB) e++;
    chk("build_seq", e, 0);
    e = 0;
    chk("beat_n", pq.size(), frames * XW);
    foreach (pq[i]) if (pq[i] != i % XW) e++;
    chk("beat_seq", e, 0);
  endtask

  function automatic logic rdy_pick(input int mode, input int c);
    case (mode)
      0: return 1'b1;
      1: return 1'($urandom % 2);
      default: return (c % 4 == 0) || (c % 4 == 3);
    endcase
  endfunction

  // mode: 0 ready=1, 1 random, 2 pattern 1,0,0,1
  task automatic run_frame(input int d, input int mode,
                           input bit rnd_start);
    int cyc = 0;
    int e;
    int acc;
    bit seen = 1'b0;
    logic rlog[$];
    bq.delete();
    pq.delete();
    wload_cnt = 0;
    done_cnt  = 0;
    start = 1'b1;
    frame_valid = 1'b0;
    q_ready = rdy_pick(mode, 0);
    rlog.push_back(q_ready);
    while (cyc < 3000) begin
      tick();
      cyc++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      start = rnd_start ? 1'($urandom % 2) : 1'b0;
      frame_valid = (cyc > d);
      q_ready = rdy_pick(mode, cyc);
      rlog.push_back(q_ready);
    end
    start = 1'b0;
    frame_valid = 1'b0;
    q_ready = 1'b0;
    chk("frame_timeout", seen, 1);
    e = d + NB + 2;
    acc = 0;
    while (acc < XW && e < rlog.size()) begin
      if (rlog[e]) acc++;
      e++;
    end
    chk("latency", cyc, e);
    tick();
    tick();
    chk("done_cnt", done_cnt, 1);
    chk("wload_cnt", wload_cnt, 1);
    chk("idle_busy", busy, 0);
    check_seqs(1);
  endtask

  initial begin
    int d0;
    int dc[$];
    bit ok;

    // reset state
    #2 rst = 1'b1;
    #1 check_zero("rst");
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check_zero("post_rst");

    // abort beats start
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start_busy", busy, 0);

    // nominal frame, minimum latency
    run_frame(0, 0, 1'b0);

    // stalls, random ready, stray starts, late frame_valid
    run_frame(0, 2, 1'b1);
    run_frame(20, 0, 1'b1);
    for (int i = 0; i < 4; i++)
      run_frame(int'($urandom_range(0, 20)), 1, 1'b1);

    // abort during build at entry 50
    done_cnt = 0;
    start = 1'b1;
    frame_valid = 1'b1;
    q_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      start = 1'b0;
      if (build_we && build_addr == 50) begin
        ok = 1'b1;
        break;
      end
    end
    chk("reach_addr50", ok, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    frame_valid = 1'b0;
    check_zero("abort_build");
    repeat (150) tick();
    chk("abort_no_done", done_cnt, 0);
    run_frame(0, 0, 1'b0);

    // abort alongside frame_valid in WAIT_W
    start = 1'b1;
    tick();
    start = 1'b0;
    frame_valid = 1'b1;
    abort = 1'b1;
    #1 chk("abort_wload", w_load, 1);
    tick();
    abort = 1'b0;
    frame_valid = 1'b0;
    check_zero("abort_wait");
    done_cnt = 0;
    repeat (150) tick();
    chk("abort_wait_no_done", done_cnt, 0);

    // three back-to-back frames via cont
    bq.delete();
    pq.delete();
    wload_cnt = 0;
    start = 1'b1;
    cont = 1'b1;
    frame_valid = 1'b1;
    q_ready = 1'b1;
    for (int c = 1; c < 1000; c++) begin
      tick();
      start = 1'b0;
      if (done) begin
        dc.push_back(c);
        if (dc.size() == 3) begin
          cont = 1'b0;
          break;
        end
      end
    end
    cont = 1'b0;
    frame_valid = 1'b0;
    chk("cont_dones", dc.size(), 3);
    if (dc.size() == 3) begin
      chk("cont_first", dc[0], 2 + NB + XW);
      chk("cont_gap1", dc[1] - dc[0], 2 + NB + XW);
      chk("cont_gap2", dc[2] - dc[1], 2 + NB + XW);
    end
    tick();
    tick();
    chk("cont_wload", wload_cnt, 3);
    chk("cont_busy", busy, 0);
    check_seqs(3);

    // reset mid-query
    start = 1'b1;
    frame_valid = 1'b1;
    q_ready = 1'b0;
    d0 = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      start = 1'b0;
      if (q_valid) begin
        d0 = 1;
        break;
      end
    end
    chk("reach_query", d0, 1);
    done_cnt = 0;
    #2 rst = 1'b1;
    #1 check_zero("rst_mid");
    tick();
    rst = 1'b0;
    frame_valid = 1'b0;
    repeat (5) tick();
    check_zero("rst_release");
    chk("rst_no_done", done_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
